fmul_normalize: RTL and testbench

FMUL_NORMALIZE -- requirements
Module: fmul_normalize

---
 rtl/fmul_normalize.sv | 161 ++++++++++++++++
 tb/tb_fmul_normalize.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fmul_normalize.sv
// fmul_normalize: two-stage normalize/round back end of a single-precision
// multiplier. Stage 1 aligns the raw mantissa product and captures guard and
// sticky bits. Stage 2 rounds, handles overflow/underflow/zero and keeps
// sticky exception flags {overflow, underflow, inexact}.
// Optional feature: define FMUL_NORMALIZE_RNE_EN for round-to-nearest-even.
// Without it the result is truncated, but inexact is still reported.
module fmul_normalize #(
    parameter int pbits = 48,
    parameter int ebits = 10
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    input  logic                    i_valid,
    input  logic                    i_sign,
    input  logic                    i_zero,
    input  logic signed [ebits-1:0] i_exp,
    input  logic [pbits-1:0]        i_mant,
    input  logic                    i_flags_clr,
    output logic                    o_valid,
    output logic [31:0]             o_result,
    output logic [2:0]              o_flags
);

    // One extra bit so that the +1 from normalization and the +1 from a
    // rounding carry can never wrap a large exponent into a small one.
    localparam int EW = ebits + 1;
    typedef logic signed [EW-1:0] exp_t;

    localparam logic [2:0] FLAG_OVF = 3'b100;
    localparam logic [2:0] FLAG_UNF = 3'b010;
    localparam logic [2:0] FLAG_INX = 3'b001;

    // ------------------------------------------------------------------
    // Stage 1: normalize
    // ------------------------------------------------------------------
    logic        v1_q;
    logic        sign1_d, sign1_q;
    logic        zero1_d, zero1_q;
    exp_t        exp_ext;
    exp_t        exp1_d, exp1_q;
    logic [22:0] frac1_d, frac1_q;
    logic        guard1_d, guard1_q;
    logic        sticky1_d, sticky1_q;

    // Pick the fraction window according to whether the product overflowed
    // into bit pbits-1, and collect guard and sticky below it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a value unassigned and no latch is inferred.
        sign1_d   = i_sign;
        zero1_d   = i_zero;
        exp_ext   = exp_t'({i_exp[ebits-1], i_exp});
        exp1_d    = exp_ext;
        frac1_d   = i_mant[pbits-3 -: 23];
        guard1_d  = i_mant[pbits-26];
        sticky1_d = |i_mant[pbits-27:0];
        if (i_mant[pbits-1]) begin
            exp1_d    = exp_ext + exp_t'(1);
            frac1_d   = i_mant[pbits-2 -: 23];
            guard1_d  = i_mant[pbits-25];
            sticky1_d = |i_mant[pbits-26:0];
        end
    end

    // Stage 1 valid bit follows the input every cycle so bubbles propagate.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!i_nrst) v1_q <= 1'b0;
        else         v1_q <= i_valid;
    end

    // Stage 1 data registers load only for valid operands and hold otherwise.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        // NOTE: the data registers are reset as well, because the result
        // register downstream must read zero during and just after reset.
        if (!i_nrst) begin
            sign1_q   <= 1'b0;
            zero1_q   <= 1'b0;
            exp1_q    <= '0;
            frac1_q   <= '0;
            guard1_q  <= 1'b0;
            sticky1_q <= 1'b0;
        end else if (i_valid) begin
            sign1_q   <= sign1_d;
            zero1_q   <= zero1_d;
            exp1_q    <= exp1_d;
            frac1_q   <= frac1_d;
            guard1_q  <= guard1_d;
            sticky1_q <= sticky1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round, classify, pack
    // ------------------------------------------------------------------
    logic        round_up;
    logic        frac_c;
    logic [22:0] frac_sum;
    exp_t        exp_r;
    logic [31:0] result_d;
    logic [2:0]  event_d;
    logic [2:0]  flags_d;

    logic        valid2_q;
    logic [31:0] result_q;
    logic [2:0]  flags_q;

    // Round the mantissa, then resolve zero/overflow/underflow/normal.
    always_comb begin
`ifdef FMUL_NORMALIZE_RNE_EN
        round_up = guard1_q & (sticky1_q | frac1_q[0]);
`else
        round_up = 1'b0;
`endif
        // The hidden bit is always 1, so a carry out of the fraction is
        // exactly the mantissa carry-out; the fraction wraps to zero.
        {frac_c, frac_sum} = {1'b0, frac1_q} + 24'(round_up);
        exp_r    = exp1_q + exp_t'({{(EW-1){1'b0}}, frac_c});
        result_d = {sign1_q, exp_r[7:0], frac_sum};
        event_d  = (guard1_q | sticky1_q) ? FLAG_INX : 3'b000;
        if (zero1_q) begin
            result_d = {sign1_q, 31'h0};
            event_d  = 3'b000;
        end else if (exp_r >= exp_t'(255)) begin
            result_d = {sign1_q, 8'hFF, 23'h0};
            event_d  = FLAG_OVF | FLAG_INX;
        end else if (exp_r <= exp_t'(0)) begin
            // Flush to zero; the true value is nonzero, so always inexact.
            result_d = {sign1_q, 31'h0};
            event_d  = FLAG_UNF | FLAG_INX;
        end
    end

    // Sticky flags: clear first, then OR in this cycle's event (event wins).
    always_comb begin
        flags_d = (i_flags_clr ? 3'b000 : flags_q) | (v1_q ? event_d : 3'b000);
    end

    // Output valid follows stage 1; the result register holds across bubbles.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            valid2_q <= 1'b0;
            result_q <= 32'h0;
        end else begin
            valid2_q <= v1_q;
            if (v1_q) result_q <= result_d;
        end
    end

    // Exception flag register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) flags_q <= 3'b000;
        else         flags_q <= flags_d;
    end

    assign o_valid  = valid2_q;
    assign o_result = result_q;
    assign o_flags  = flags_q;

endmodule

// File: tb/tb_fmul_normalize.sv
// tb_fmul_normalize: directed scoreboard bench for fmul_normalize.
// Each cycle the bench first checks the DUT outputs (on the falling edge)
// against the entry queued two cycles earlier, then drives the next inputs.
// Expected flags are tracked as a sticky set from the queued events.
module tb_fmul_normalize;

    localparam int PB = 48;
    localparam int EB = 10;

    localparam logic [2:0] F_OVF = 3'b100;
    localparam logic [2:0] F_UNF = 3'b010;
    localparam logic [2:0] F_INX = 3'b001;
    localparam logic [2:0] F_NONE = 3'b000;

`ifdef FMUL_NORMALIZE_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    localparam logic [PB-1:0] M46 = 48'h4000_0000_0000;
    localparam logic [PB-1:0] M47 = 48'h8000_0000_0000;

    logic                 i_clk;
    logic                 i_nrst;
    logic                 i_valid;
    logic                 i_sign;
    logic                 i_zero;
    logic signed [EB-1:0] i_exp;
    logic [PB-1:0]        i_mant;
    logic                 i_flags_clr;
    logic                 o_valid;
    logic [31:0]          o_result;
    logic [2:0]           o_flags;

    fmul_normalize #(.pbits(PB), .ebits(EB)) dut (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_valid     (i_valid),
        .i_sign      (i_sign),
        .i_zero      (i_zero),
        .i_exp       (i_exp),
        .i_mant      (i_mant),
        .i_flags_clr (i_flags_clr),
        .o_valid     (o_valid),
        .o_result    (o_result),
        .o_flags     (o_flags)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [2:0]  ev;
    } exp_item_t;

    exp_item_t  sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] model_flags;
    logic       last_clr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Compare outputs against the entry that entered the pipe two cycles ago.
    task automatic observe();
        exp_item_t e;
        e = '0;
        if (sb.size() >= 2) e = sb.pop_front();
        model_flags = (last_clr ? F_NONE : model_flags) | (e.valid ? e.ev : F_NONE);
        check("o_valid", {31'b0, o_valid}, {31'b0, e.valid});
        if (e.valid) check("o_result", o_result, e.result);
        check("o_flags", {29'b0, o_flags}, {29'b0, model_flags});
    endtask

    task automatic tick(input logic v, input logic s, input logic z,
                        input logic signed [EB-1:0] e, input logic [PB-1:0] m,
                        input logic clr, input logic [31:0] res, input logic [2:0] ev);
        exp_item_t it;
        @(negedge i_clk);
        observe();
        i_valid     = v;
        i_sign      = s;
        i_zero      = z;
        i_exp       = e;
        i_mant      = m;
        i_flags_clr = clr;
        last_clr    = clr;
        it.valid    = v;
        it.result   = res;
        it.ev       = ev;
        sb.push_back(it);
    endtask

    task automatic op(input logic s, input logic signed [EB-1:0] e, input logic [PB-1:0] m,
                      input logic [31:0] res, input logic [2:0] ev);
        tick(1'b1, s, 1'b0, e, m, 1'b0, res, ev);
    endtask

    task automatic idle(input logic clr);
        tick(1'b0, 1'b0, 1'b0, '0, '0, clr, 32'h0, F_NONE);
    endtask

    // Reset with valid and clear held high to show reset dominates them.
    task automatic pulse_reset();
        @(negedge i_clk);
        i_nrst      = 1'b0;
        i_valid     = 1'b1;
        i_flags_clr = 1'b1;
        #1;
        check("rst_valid", {31'b0, o_valid}, 32'h0);
        check("rst_result", o_result, 32'h0);
        check("rst_flags", {29'b0, o_flags}, 32'h0);
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_hold_valid", {31'b0, o_valid}, 32'h0);
        check("rst_hold_result", o_result, 32'h0);
        @(negedge i_clk);
        i_valid     = 1'b0;
        i_flags_clr = 1'b0;
        i_nrst      = 1'b1;
        sb.delete();
        model_flags = F_NONE;
        last_clr    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    initial begin
        i_nrst      = 1'b0;
        i_valid     = 1'b0;
        i_sign      = 1'b0;
        i_zero      = 1'b0;
        i_exp       = '0;
        i_mant      = '0;
        i_flags_clr = 1'b0;
        model_flags = F_NONE;
        last_clr    = 1'b0;

        repeat (2) @(negedge i_clk);
        check("init_valid", {31'b0, o_valid}, 32'h0);
        check("init_result", o_result, 32'h0);
        check("init_flags", {29'b0, o_flags}, 32'h0);
        i_nrst = 1'b1;

        // Exact products, a bubble and a zero operand.
        op(1'b0, 10'sd127, M46,               32'h3F80_0000, F_NONE);
        op(1'b0, 10'sd127, 48'h9000_0000_0000, 32'h4010_0000, F_NONE);
        idle(1'b0);
        tick(1'b1, 1'b1, 1'b1, 10'sd300, M47, 1'b0, 32'h8000_0000, F_NONE);

        // Rounding: lsb set with guard, tie to even, carry-outs.
        op(1'b0, 10'sd127, M46 + 48'h80_0000 + 48'h40_0000,
           RNE ? 32'h3F80_0002 : 32'h3F80_0001, F_INX);
        op(1'b0, 10'sd127, M46 + 48'h40_0000, 32'h3F80_0000, F_INX);
        op(1'b0, 10'sd127, 48'h7FFF_FFFF_FFFF,
           RNE ? 32'h4000_0000 : 32'h3FFF_FFFF, F_INX);
        op(1'b0, 10'sd127, 48'hFFFF_FFFF_FFFF,
           RNE ? 32'h4080_0000 : 32'h407F_FFFF, F_INX);

        // Exponent boundaries just inside the normal range.
        op(1'b1, 10'sd0,   M47, 32'h8080_0000, F_NONE);
        op(1'b0, 10'sd253, M47, 32'h7F00_0000, F_NONE);
        idle(1'b1);

        // Overflow: direct, via rounding carry, and at the largest exponent.
        op(1'b0, 10'sd254, M47, 32'h7F80_0000, F_OVF | F_INX);
        op(1'b0, 10'sd253, 48'hFFFF_FFFF_FFFF,
           RNE ? 32'h7F80_0000 : 32'h7F7F_FFFF, RNE ? (F_OVF | F_INX) : F_INX);
        op(1'b0, 10'sd511, M46, 32'h7F80_0000, F_OVF | F_INX);

        // Underflow completing in the same cycle as a flag clear.
        op(1'b0, 10'sd0, M46, 32'h0000_0000, F_UNF | F_INX);
        idle(1'b1);
        op(1'b1, -10'sd5,   M46,               32'h8000_0000, F_UNF | F_INX);
        op(1'b1, -10'sd512, 48'hFFFF_FFFF_FFFF, 32'h8000_0000, F_UNF | F_INX);

        // Back-to-back stream with one bubble.
        op(1'b0, 10'sd130, M46,               32'h4100_0000, F_NONE);
        op(1'b1, 10'sd100, M47,               32'hB280_0000, F_NONE);
        idle(1'b0);
        op(1'b0, 10'sd200, 48'hC000_0000_0000, 32'h64C0_0000, F_NONE);
        op(1'b0, 10'sd1,   M46,               32'h0080_0000, F_NONE);

        // Two operands in flight when reset hits; both must be dropped.
        op(1'b0, 10'sd127, M46, 32'h3F80_0000, F_NONE);
        op(1'b0, 10'sd128, M46, 32'h4000_0000, F_NONE);
        pulse_reset();

        // First post-reset operand appears exactly two cycles later.
        op(1'b0, 10'sd127, 48'h9000_0000_0000, 32'h4010_0000, F_NONE);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
